paddsb_seq_ctrl: RTL and testbench

//  Time-multiplexed sequencer for the packed sub-word add (PADDSB) path in the execute stage.

---
 rtl/paddsb_pkg.sv | 14 +
 rtl/paddsb_lane_alu.sv | 32 +++
 rtl/paddsb_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_paddsb_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddsb_pkg.sv
// Shared definitions for the PADDSB sequencer: lane geometry, FSM encoding and lane clamp values.
package paddsb_pkg;

   localparam int PKG_NW    = 4;
   localparam int PKG_LANES = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [PKG_NW-1:0] SAT_POS = {1'b0, {(PKG_NW-1){1'b1}}};
   localparam logic [PKG_NW-1:0] SAT_NEG = {1'b1, {(PKG_NW-1){1'b0}}};

endpackage

// File: rtl/paddsb_lane_alu.sv
// Combinational NW-bit signed add/sub lane with overflow detect.
// Macro PADDSB_SATURATE_EN clamps overflowed lanes instead of wrapping.
module paddsb_lane_alu
   import paddsb_pkg::*;
#(
   parameter int NW = PKG_NW
) (
   input  logic [NW-1:0] i_a,
   input  logic [NW-1:0] i_b,
   input  logic          i_sub,
   output logic [NW-1:0] o_sum,
   output logic          o_ovfl
);

   localparam logic [NW-1:0] L_SAT_POS = {1'b0, {(NW-1){1'b1}}};
   localparam logic [NW-1:0] L_SAT_NEG = {1'b1, {(NW-1){1'b0}}};

   logic [NW-1:0] w_b_eff;
   logic [NW-1:0] w_raw;

   assign w_b_eff = i_sub ? ~i_b : i_b;
   assign w_raw   = i_a + w_b_eff + {{(NW-1){1'b0}}, i_sub};
   assign o_ovfl  = (i_a[NW-1] == w_b_eff[NW-1]) && (w_raw[NW-1] != i_a[NW-1]);

`ifdef PADDSB_SATURATE_EN
   // Overflow direction follows the operand sign: positive operands can only overflow upward.
   assign o_sum = o_ovfl ? (i_a[NW-1] ? L_SAT_NEG : L_SAT_POS) : w_raw;
`else
   assign o_sum = w_raw;
`endif

endmodule

// File: rtl/paddsb_seq_ctrl.sv
// Time-multiplexed packed sub-word add/sub: one lane ALU stepped across all lanes, valid/ready I/O.
// Optional macro PADDSB_SATURATE_EN selects clamping of overflowed lanes.
module paddsb_seq_ctrl
   import paddsb_pkg::*;
#(
   parameter int NW    = PKG_NW,
   parameter int LANES = PKG_LANES
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [NW*LANES-1:0]   i_in_a,
   input  logic [NW*LANES-1:0]   i_in_b,
   input  logic                  i_in_sub,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [NW*LANES-1:0]   o_out_sum,
   output logic [LANES-1:0]      o_out_ovfl,
   output logic                  o_out_err
);

   localparam int DW  = NW * LANES;
   localparam int LIW = $clog2(LANES);

   logic [1:0]       r_state;
   logic [LIW-1:0]   r_idx;
   logic [DW-1:0]    r_a;
   logic [DW-1:0]    r_b;
   logic             r_sub;
   logic [DW-1:0]    r_sum;
   logic [LANES-1:0] r_ovfl;
   logic             r_err;
   logic             r_out_valid;

   logic [NW-1:0]    w_lane_a;
   logic [NW-1:0]    w_lane_b;
   logic [NW-1:0]    w_lane_sum;
   logic             w_lane_ovfl;
   logic [DW-1:0]    w_sum_next;
   logic [LANES-1:0] w_ovfl_next;
   logic             w_last;

   assign w_lane_a = r_a[NW*r_idx +: NW];
   assign w_lane_b = r_b[NW*r_idx +: NW];
   assign w_last   = (r_idx == LIW'(LANES-1));

   paddsb_lane_alu #(.NW(NW)) u_lane_alu (
      .i_a    (w_lane_a),
      .i_b    (w_lane_b),
      .i_sub  (r_sub),
      .o_sum  (w_lane_sum),
      .o_ovfl (w_lane_ovfl)
   );

   // Result vectors with the current lane slot replaced by the lane ALU output.
   always_comb begin
      w_sum_next               = r_sum;
      w_ovfl_next              = r_ovfl;
      w_sum_next[NW*r_idx +: NW] = w_lane_sum;
      w_ovfl_next[r_idx]       = w_lane_ovfl;
   end

   // FSM, lane counter, operand and result registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_sub       <= 1'b0;
         r_sum       <= '0;
         r_ovfl      <= '0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_in_valid) begin
                  r_a     <= i_in_a;
                  r_b     <= i_in_b;
                  r_sub   <= i_in_sub;
                  r_sum   <= '0;
                  r_ovfl  <= '0;
                  r_err   <= 1'b0;
                  r_idx   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_sum  <= w_sum_next;
               r_ovfl <= w_ovfl_next;
               if (w_last) begin
                  r_idx       <= '0;
                  r_err       <= |w_ovfl_next;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_idx <= r_idx + LIW'(1);
               end
            end
            ST_DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_idx       <= '0;
               r_out_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = (r_state == ST_IDLE);
   assign o_out_valid = r_out_valid;
   assign o_out_sum   = r_sum;
   assign o_out_ovfl  = r_ovfl;
   assign o_out_err   = r_err;

endmodule

// File: tb/tb_paddsb_seq_ctrl.sv
// Self-checking bench for paddsb_seq_ctrl: directed scenarios plus randomized traffic vs a lane model.
// Honours PADDSB_SATURATE_EN in its reference model.
module tb_paddsb_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic [3:0]  out_ovfl;
   logic        out_err;

   int checks = 0;
   int errors = 0;

   paddsb_seq_ctrl dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_a      (in_a),
      .i_in_b      (in_b),
      .i_in_sub    (in_sub),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_sum   (out_sum),
      .o_out_ovfl  (out_ovfl),
      .o_out_err   (out_err)
   );

   always #5 clk = ~clk;

   // Lane-wise reference: signed integer add/sub per nibble, then range check.
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                 output logic [15:0] s, output logic [3:0] ov);
      s  = 16'h0000;
      ov = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         int va, vb, r;
         logic [3:0] na, nb, res;
         na = a[4*i +: 4];
         nb = b[4*i +: 4];
         va = (na >= 4'd8) ? int'(na) - 16 : int'(na);
         vb = (nb >= 4'd8) ? int'(nb) - 16 : int'(nb);
         r  = sub ? va - vb : va + vb;
         res = r[3:0];
         if (r > 7 || r < -8) begin
            ov[i] = 1'b1;
`ifdef PADDSB_SATURATE_EN
            res = (r > 7) ? 4'h7 : 4'h8;
`endif
         end
         s[4*i +: 4] = res;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair until accepted; returns 1 if accepted within the bound.
   task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                            output bit ok);
      logic rdy;
      ok       = 1'b0;
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      for (int k = 0; k < 30 && !ok; k++) begin
         rdy = in_ready;
         tick();
         if (rdy) ok = 1'b1;
      end
      in_valid = 1'b0;
   endtask

   // Cycles from the accept edge until out_valid is seen (0 on timeout).
   task automatic wait_valid(output int cyc);
      cyc = 0;
      for (int k = 1; k <= 30 && cyc == 0; k++) begin
         tick();
         if (out_valid) cyc = k;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 16'h0; in_b = 16'h0; in_sub = 1'b0;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      checks++;
      if (out_sum !== 16'h0 || out_ovfl !== 4'h0 || out_err !== 1'b0) begin
         errors++; $display("FAIL reset_data: sum=%h ovfl=%b err=%b want 0", out_sum, out_ovfl, out_err);
      end
   endtask

   task automatic run_directed(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic sub, input logic [15:0] exp_sum, input logic [3:0] exp_ov);
      bit ok;
      int cyc;
      out_ready = 1'b0;
      accept_op(a, b, sub, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL %s_accept: not accepted", name);
      end
      wait_valid(cyc);
      checks++;
      if (cyc != 4) begin
         errors++; $display("FAIL %s_latency: got %0d cycles want 4", name, cyc);
      end
      checks++;
      if (out_sum !== exp_sum || out_ovfl !== exp_ov || out_err !== (|exp_ov)) begin
         errors++;
         $display("FAIL %s_result: sum=%h ovfl=%b err=%b want %h %b %b",
                  name, out_sum, out_ovfl, out_err, exp_sum, exp_ov, |exp_ov);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_basic();
      run_directed("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 4'b0000);
   endtask

   task automatic test_overflow();
`ifdef PADDSB_SATURATE_EN
      run_directed("ovfl", 16'h7788, 16'h1188, 1'b0, 16'h7788, 4'b1111);
`else
      run_directed("ovfl", 16'h7788, 16'h1188, 1'b0, 16'h8800, 4'b1111);
`endif
   endtask

   task automatic test_subtract();
      run_directed("sub0", 16'h0000, 16'h0001, 1'b1, 16'h000F, 4'b0000);
`ifdef PADDSB_SATURATE_EN
      run_directed("sub1", 16'h8000, 16'h1000, 1'b1, 16'h8000, 4'b1000);
`else
      run_directed("sub1", 16'h8000, 16'h1000, 1'b1, 16'h7000, 4'b1000);
`endif
   endtask

   task automatic test_backpressure();
      bit ok;
      int cyc;
      logic [15:0] s0, s1;
      logic [3:0]  o0, o1;
      model(16'h5A3C, 16'h2B71, 1'b0, s0, o0);
      model(16'h9F06, 16'h3C7E, 1'b1, s1, o1);
      out_ready = 1'b0;
      accept_op(16'h5A3C, 16'h2B71, 1'b0, ok);
      wait_valid(cyc);
      checks++;
      if (cyc != 4) begin
         errors++; $display("FAIL bp_latency: got %0d want 4", cyc);
      end
      in_a = 16'h9F06; in_b = 16'h3C7E; in_sub = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== s0 || out_err !== (|o0)) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b ready=%b sum=%h err=%b want 1 0 %h %b",
                     k, out_valid, in_ready, out_sum, out_err, s0, |o0);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      wait_valid(cyc);
      checks++;
      if (cyc != 4 || out_sum !== s1 || out_ovfl !== o1) begin
         errors++;
         $display("FAIL bp_b2b: cyc=%0d sum=%h ovfl=%b want 4 %h %b", cyc, out_sum, out_ovfl, s1, o1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      bit seen;
      out_ready = 1'b1;
      accept_op(16'h7788, 16'h1188, 1'b0, ok);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_ovfl !== 4'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst: valid=%b sum=%h ovfl=%b ready=%b want 0 0 0 1",
                  out_valid, out_sum, out_ovfl, in_ready);
      end
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL midrst_stale: out_valid=1 want 0");
      end
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] q_sum[$];
      logic [3:0]  q_ov[$];
      logic [15:0] es, snap_sum;
      logic [3:0]  eo, snap_ov;
      logic        snap_err;
      bit pending, acc_now, out_now;
      int gap, accepts, outs, cycles;
      pending = 1'b0; gap = 0; accepts = 0; outs = 0; cycles = 0;
      while (outs < 200 && cycles < 20000) begin
         if (!pending && accepts < 200 && gap == 0) begin
            in_a    = 16'($urandom);
            in_b    = 16'($urandom);
            in_sub  = 1'($urandom);
            pending = 1'b1;
         end
         in_valid  = pending;
         out_ready = ($urandom_range(0, 3) != 0);
         acc_now   = pending && in_ready;
         out_now   = out_valid && out_ready;
         snap_sum  = out_sum;
         snap_ov   = out_ovfl;
         snap_err  = out_err;
         tick();
         cycles++;
         if (acc_now) begin
            model(in_a, in_b, in_sub, es, eo);
            q_sum.push_back(es);
            q_ov.push_back(eo);
            pending = 1'b0;
            accepts++;
            gap = $urandom_range(0, 3);
         end else if (!pending && gap > 0) begin
            gap--;
         end
         if (out_now) begin
            outs++;
            checks++;
            if (q_sum.size() == 0) begin
               errors++; $display("FAIL rnd_spurious: output with no accepted op");
            end else begin
               es = q_sum.pop_front();
               eo = q_ov.pop_front();
               if (snap_sum !== es || snap_ov !== eo || snap_err !== (|eo)) begin
                  errors++;
                  $display("FAIL rnd_result[%0d]: sum=%h ovfl=%b err=%b want %h %b %b",
                           outs, snap_sum, snap_ov, snap_err, es, eo, |eo);
               end
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (accepts != 200 || outs != 200 || q_sum.size() != 0) begin
         errors++;
         $display("FAIL rnd_count: accepts=%0d outputs=%0d pending=%0d want 200 200 0",
                  accepts, outs, q_sum.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_subtract();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
